// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: settle/acquire/output sequencer for the delta-ADC loop.
// Define ADC_SEQ_RANGE_FLAG_EN to add the range_flag output.
module adc_sample_sequencer #(
  parameter int W        = 16,
  parameter int DIV_W    = 16,
  parameter int SETTLE_W = 8,
  parameter int LOG2_AVG = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [SETTLE_W-1:0] settle_cnt,
  output logic                sampling_strb,
  input  logic                fsm_enable,
  input  logic [W-1:0]        fsm_next_value,
  output logic [W-1:0]        ADC_value,
  output logic [W-1:0]        result_data,
  output logic                result_valid,
  input  logic                result_ready,
`ifdef ADC_SEQ_RANGE_FLAG_EN
  output logic                range_flag,
`endif
  output logic                busy
);

  localparam int AW = W + LOG2_AVG;
  localparam logic [LOG2_AVG:0] LAST =
    (LOG2_AVG+1)'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACQUIRE,
    OUTPUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    clk_div_lat;
  logic [SETTLE_W-1:0] settle_lat;
  logic [SETTLE_W-1:0] settle_num;
  logic [LOG2_AVG:0]   smp_num;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;

  logic go;
  logic kill;
  logic hs;
  logic settled;
  logic take;
  logic last_smp;
  logic div_hit;
  logic acq_entry;

  always_comb begin
    go       = (state == IDLE) && start && !abort;
    kill     = (state != IDLE) && abort;
    hs       = (state == OUTPUT) && result_ready;
    settled  = (state == SETTLE) && (settle_num == settle_lat);
    take     = (state == ACQUIRE) && fsm_enable;
    last_smp = take && (smp_num == LAST);
    div_hit  = (div_cnt == clk_div_lat);
    sum      = acc + AW'(fsm_next_value);
  end

  always_comb begin
    state_nx = state;
    if (kill) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (go)       state_nx = SETTLE;
        SETTLE:  if (settled)  state_nx = ACQUIRE;
        ACQUIRE: if (last_smp) state_nx = OUTPUT;
        OUTPUT:  if (hs)       state_nx = continuous ? ACQUIRE : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign acq_entry = (state_nx == ACQUIRE) && (state != ACQUIRE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_div_lat <= '0;
      settle_lat  <= '0;
    end else if (go) begin
      clk_div_lat <= clk_div;
      settle_lat  <= settle_cnt;
    end
  end

  // Strobe is registered and gated by the next state so that it never
  // fires in the cycle after the sequence returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt       <= '0;
      sampling_strb <= 1'b0;
    end else begin
      sampling_strb <= busy && (state_nx != IDLE) && div_hit;
      if (!busy || (state_nx == IDLE)) div_cnt <= '0;
      else if (div_hit)                div_cnt <= '0;
      else                             div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        ADC_value <= '0;
    else if (fsm_enable) ADC_value <= fsm_next_value;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_num <= '0;
    end else if (go) begin
      settle_num <= '0;
    end else if ((state == SETTLE) && fsm_enable && !settled) begin
      settle_num <= settle_num + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_num <= '0;
    end else if (acq_entry || kill) begin
      smp_num <= '0;
    end else if (take) begin
      smp_num <= last_smp ? '0 : smp_num + 1'b1;
    end
  end

  // The final sample goes straight into the result, so acc is
  // already empty while the result waits in OUTPUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (go || kill || hs || last_smp) begin
      acc <= '0;
    end else if (take) begin
      acc <= sum;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_data  <= '0;
      result_valid <= 1'b0;
    end else if (kill || hs) begin
      result_valid <= 1'b0;
    end else if (last_smp) begin
      result_data  <= sum[AW-1:LOG2_AVG];
      result_valid <= 1'b1;
    end
  end

`ifdef ADC_SEQ_RANGE_FLAG_EN
  logic rail;
  assign rail = (fsm_next_value == '0) || (&fsm_next_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      range_flag <= 1'b0;
    end else if (acq_entry) begin
      range_flag <= 1'b0;
    end else if (take && !kill && rail) begin
      range_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: directed bench for adc_sample_sequencer.
// Models the up/down FSM as a one-cycle-latency value source.
module tb_adc_sample_sequencer;

  localparam int W        = 16;
  localparam int DIV_W    = 16;
  localparam int SETTLE_W = 8;
  localparam int LOG2_AVG = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                continuous = 1'b0;
  logic [DIV_W-1:0]    clk_div = '0;
  logic [SETTLE_W-1:0] settle_cnt = '0;
  logic                sampling_strb;
  logic                fsm_enable = 1'b0;
  logic [W-1:0]        fsm_next_value = '0;
  logic [W-1:0]        ADC_value;
  logic [W-1:0]        result_data;
  logic                result_valid;
  logic                result_ready = 1'b0;
  logic                busy;
`ifdef ADC_SEQ_RANGE_FLAG_EN
  logic                range_flag;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int at = 0;
  int k = 0;
  int base = 0;
  int step = 0;
  int ff_idx = -1;
  int en_cnt = 0;
  int last_en = 0;
  int prev_strb = -1;
  int strb_cnt = 0;
  int strb0 = 0;
  int exp_per = 4;
  logic pend = 1'b0;

  adc_sample_sequencer #(
    .W(W), .DIV_W(DIV_W), .SETTLE_W(SETTLE_W), .LOG2_AVG(LOG2_AVG)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .continuous(continuous),
    .clk_div(clk_div),
    .settle_cnt(settle_cnt),
    .sampling_strb(sampling_strb),
    .fsm_enable(fsm_enable),
    .fsm_next_value(fsm_next_value),
    .ADC_value(ADC_value),
    .result_data(result_data),
    .result_valid(result_valid),
    .result_ready(result_ready),
`ifdef ADC_SEQ_RANGE_FLAG_EN
    .range_flag(range_flag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mval(input int n);
    if (n == ff_idx) return {W{1'b1}};
    return W'(base + step * n);
  endfunction

  // One clock: the FSM model answers a strobe one cycle later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    fsm_enable = pend;
    if (pend) begin
      fsm_next_value = mval(k);
      k++;
      en_cnt++;
      last_en = cyc;
    end
    pend = sampling_strb;
    if (sampling_strb) begin
      strb_cnt++;
      if (prev_strb >= 0) chk("strb_period", cyc - prev_strb, exp_per);
      prev_strb = cyc;
    end
  endtask

  task automatic do_start(input logic [DIV_W-1:0] d,
                          input logic [SETTLE_W-1:0] s);
    clk_div    = d;
    settle_cnt = s;
    start      = 1'b1;
    prev_strb  = -1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_valid(input string tag, output int when);
    when = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (result_valid) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) chk({tag, "_timeout"}, result_valid, 1);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    // Reset with start held high
    start   = 1'b1;
    clk_div = 3;
    repeat (3) tick();
    chk("rst_strb", sampling_strb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_data", result_data, 0);
    chk("rst_adc", ADC_value, 0);
    chk("rst_acc", dut.acc, 0);
    start = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("idle_busy", busy, 0);
    chk("idle_strb_cnt", strb_cnt, 0);

    // Constant 100, settle 2, divider 3 (later change of clk_div ignored)
    base = 100; step = 0; k = 0; en_cnt = 0; exp_per = 4;
    do_start(3, 2);
    chk("start_busy", busy, 1);
    clk_div = 9;
    wait_valid("t2", at);
    chk("t2_latency", at - s_cyc, 42);
    chk("t2_after_last_en", at - last_en, 1);
    chk("t2_enables", en_cnt, 10);
    chk("t2_data", result_data, 100);
    chk("t2_adc", ADC_value, 100);
    repeat (3) tick();
    chk("t2_hold_valid", result_valid, 1);
    chk("t2_hold_data", result_data, 100);
    handshake();
    chk("t2_hs_valid", result_valid, 0);
    chk("t2_hs_busy", busy, 0);
    strb0 = strb_cnt;
    repeat (8) tick();
    chk("t2_idle_strb", strb_cnt - strb0, 0);

    // Samples 10..17 after two settle values, continuous mode
    continuous = 1'b1;
    base = 8; step = 1; k = 0; en_cnt = 0;
    do_start(3, 2);
    wait_valid("t3", at);
    chk("t3_data", result_data, 13);
    chk("t3_adc", ADC_value, 17);

    // Long stall in OUTPUT, then direct re-acquire of constant 50
    base = 50; step = 0;
    strb0 = strb_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_hold_valid", result_valid, 1);
      chk("t4_hold_data", result_data, 13);
      chk("t4_acc_zero", dut.acc, 0);
    end
    chk("t4_strobes", strb_cnt - strb0, 5);
    en_cnt = 0;
    handshake();
    chk("t4_hs_busy", busy, 1);
    chk("t4_hs_valid", result_valid, 0);
    wait_valid("t4", at);
    chk("t4_enables", en_cnt, 8);
    chk("t4_data", result_data, 50);

    // Abort after three ACQUIRE samples
    continuous = 1'b0;
    handshake();
    chk("t5_idle", busy, 0);
    base = 60; step = 1; k = 0; en_cnt = 0;
    do_start(3, 2);
    for (int i = 0; i < 100; i++) begin
      if (en_cnt >= 5) break;
      tick();
    end
    chk("t5_setup", en_cnt, 5);
    tick();
    chk("t5_adc_pre", ADC_value, 64);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_strb", sampling_strb, 0);
    chk("t5_valid", result_valid, 0);
    strb0 = strb_cnt;
    repeat (12) tick();
    chk("t5_no_strb", strb_cnt - strb0, 0);
    chk("t5_adc_kept", ADC_value, 64);
    chk("t5_data_kept", result_data, 50);
    chk("t5_acc", dut.acc, 0);

    // Fresh run: 30,31 discarded, 32..39 averaged
    base = 30; step = 1; k = 0; en_cnt = 0;
    do_start(3, 2);
    wait_valid("t5b", at);
    chk("t5b_latency", at - s_cyc, 42);
    chk("t5b_enables", en_cnt, 10);
    chk("t5b_data", result_data, 35);
    handshake();
    chk("t5b_idle", busy, 0);

`ifdef ADC_SEQ_RANGE_FLAG_EN
    // Rail sample flags the result; next clean acquisition clears it
    continuous = 1'b1;
    base = 1; step = 0; ff_idx = 3; k = 0;
    do_start(3, 0);
    wait_valid("t6a", at);
    chk("t6a_data", result_data, 8192);
    chk("t6a_flag", range_flag, 1);
    repeat (2) tick();
    chk("t6a_flag_hold", range_flag, 1);
    ff_idx = -1; base = 1; step = 1; k = 0;
    handshake();
    wait_valid("t6b", at);
    chk("t6b_data", result_data, 4);
    chk("t6b_flag", range_flag, 0);
    continuous = 1'b0;
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
